// File: rtl/pa_risc_pkg.sv
// Shared types and constants for the PA-RISC pipeline front end.
package pa_risc_pkg;
    localparam int          INSTR_W   = 32;
    localparam logic [31:0] PC_INC    = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory bus: fetch stage (master) drives the byte address, memory returns the word combinationally.
interface fetch_stage_if #(parameter int ADDR_W = 8);
    import pa_risc_pkg::*;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;

    modport master (output imem_addr, input  imem_data);
    modport slave  (input  imem_addr, output imem_data);
endinterface

// File: rtl/fetch_stage_pc_npc.sv
// PC/nPC pair for PA-RISC delayed branching: PC always follows nPC, a taken branch only redirects nPC.
module pc_npc_reg
    import pa_risc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] pc,
    output logic [31:0] npc
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc  <= RESET_PC;
            npc <= RESET_PC + PC_INC;
        end else if (advance) begin
            pc  <= npc;
            // Low two target bits carry privilege level, never part of the address.
            npc <= br_taken ? {br_target[31:2], 2'b00} : npc + PC_INC;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC/nPC, IF/ID register and BOOT/RUN/HALT control.
// Optional macro FETCH_STATS_EN adds saturating fetch_cnt/stall_cnt outputs.
module fetch_stage
    import pa_risc_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [31:0]        br_target,
    input  logic               if_id_flush,
    input  logic               halt_req,
    input  logic               resume,
    fetch_stage_if.master      imem,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [31:0]        if_id_pc,
    output logic               if_id_valid,
    output logic               halted
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]        fetch_cnt,
    output logic [15:0]        stall_cnt
`endif
);
    fetch_state_t state, state_nxt;
    logic         advance, kill_valid;
    logic [31:0]  pc, npc;

    pc_npc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance   (advance),
        .br_taken  (br_taken),
        .br_target (br_target),
        .pc        (pc),
        .npc       (npc)
    );

    assign imem.imem_addr = pc[ADDR_W-1:0];
    assign halted         = (state == HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        advance    = 1'b0;
        kill_valid = 1'b0;
        case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                if (halt_req) begin
                    state_nxt  = HALT;
                    kill_valid = 1'b1;
                end else if (stall) begin
                    // Flush still nullifies the held slot even while stalled.
                    kill_valid = if_id_flush;
                end else begin
                    advance = 1'b1;
                end
            end
            HALT: if (resume && !halt_req) state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= 32'h0;
            if_id_valid <= 1'b0;
        end else if (advance) begin
            if_id_instr <= imem.imem_data;
            if_id_pc    <= pc;
            if_id_valid <= ~if_id_flush;
        end else if (kill_valid) begin
            if_id_valid <= 1'b0;
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= 16'h0;
            stall_cnt <= 16'h0;
        end else begin
            if (advance && !if_id_flush && fetch_cnt != 16'hFFFF)
                fetch_cnt <= fetch_cnt + 16'h1;
            if (state == RUN && stall && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'h1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: random and directed stimulus against a cycle-level reference model.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, br_taken = 1'b0, if_id_flush = 1'b0, halt_req = 1'b0, resume = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic [31:0] if_id_instr, if_id_pc;
    logic        if_id_valid, halted;
`ifdef FETCH_STATS_EN
    logic [15:0] fetch_cnt, stall_cnt;
`endif

    logic [31:0] mem [64];
    fetch_stage_if #(.ADDR_W(8)) imem();
    assign imem.imem_data = mem[imem.imem_addr[7:2]];

    fetch_stage #(.ADDR_W(8), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .if_id_flush(if_id_flush), .halt_req(halt_req), .resume(resume), .imem(imem),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid), .halted(halted)
`ifdef FETCH_STATS_EN
        , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        h;
        logic [7:0]  addr;
        int          fc;
        int          sc;
    } exp_t;
    exp_t q[$];

    int checks = 0, errors = 0;

    // Reference model: architectural PC/nPC plus the visible IF/ID slot.
    logic [31:0] m_pc, m_npc, m_ipc, m_instr;
    logic        m_v;
    int          m_mode;  // 0 boot, 1 run, 2 halt
    int          m_fc, m_sc;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_npc = 32'h4; m_ipc = 32'h0; m_instr = 32'h0;
        m_v = 1'b0; m_mode = 0; m_fc = 0; m_sc = 0;
    endtask

    // Drive one cycle's inputs (at a negedge), predict the next edge, push it.
    task automatic cyc(input logic st, input logic bt, input logic [31:0] tgt,
                       input logic fl, input logic hr, input logic rs);
        exp_t e;
        stall = st; br_taken = bt; br_target = tgt; if_id_flush = fl; halt_req = hr; resume = rs;
        case (m_mode)
            0: m_mode = 1;
            1: begin
                if (st && m_sc < 65535) m_sc++;
                if (hr) begin
                    m_mode = 2; m_v = 1'b0;
                end else if (st) begin
                    if (fl) m_v = 1'b0;
                end else begin
                    m_instr = mem[m_pc[7:2]];
                    m_ipc   = m_pc;
                    m_v     = !fl;
                    if (!fl && m_fc < 65535) m_fc++;
                    m_pc    = m_npc;
                    m_npc   = bt ? (tgt & 32'hFFFF_FFFC) : m_npc + 32'd4;
                end
            end
            default: if (rs && !hr) m_mode = 1;
        endcase
        e.v = m_v; e.pc = m_ipc; e.instr = m_instr; e.h = (m_mode == 2);
        e.addr = m_pc[7:0]; e.fc = m_fc; e.sc = m_sc;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 32'h0, 0, 0, 0);
    endtask

    // Called at a negedge; reset lands asynchronously between edges.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        chk("rst_addr",   {24'h0, imem.imem_addr}, 32'h0);
        chk("rst_valid",  {31'h0, if_id_valid}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        chk("rst_pc",     if_id_pc, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("valid",  {31'h0, if_id_valid}, {31'h0, e.v});
            chk("if_pc",  if_id_pc, e.pc);
            chk("instr",  if_id_instr, e.instr);
            chk("halted", {31'h0, halted}, {31'h0, e.h});
            chk("addr",   {24'h0, imem.imem_addr}, {24'h0, e.addr});
`ifdef FETCH_STATS_EN
            chk("fetch_cnt", {16'h0, fetch_cnt}, e.fc);
            chk("stall_cnt", {16'h0, stall_cnt}, e.sc);
`endif
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        model_reset();
        @(negedge clk);
        do_reset();

        // Boot, sequential fetch, delayed branch to 0x40, then 0x43 masked to 0x40.
        idle(3);
        cyc(0, 1, 32'h40, 0, 0, 0);
        idle(2);
        cyc(0, 1, 32'h43, 0, 0, 0);
        idle(3);

        // Stall at PC=16, flush with/without stall, halt at PC=20.
        do_reset();
        idle(5);
        repeat (3) cyc(1, 1, 32'h80, 0, 0, 0);
        cyc(0, 0, 32'h0, 0, 0, 0);
        cyc(1, 0, 32'h0, 1, 0, 0);
        cyc(0, 0, 32'h0, 1, 0, 0);
        do_reset();
        idle(6);
        cyc(0, 0, 32'h0, 0, 1, 0);
        idle(5);
        cyc(0, 0, 32'h0, 0, 1, 1);
        cyc(0, 0, 32'h0, 0, 0, 1);
        idle(2);

        // nPC wrap from 0xFFFF_FFFC to 0.
        cyc(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        idle(4);

`ifdef FETCH_STATS_EN
        do_reset();
        idle(11);
        repeat (2) cyc(1, 0, 32'h0, 0, 0, 0);
        chk("stats_fetch10", {16'h0, fetch_cnt}, 32'd10);
        chk("stats_stall2",  {16'h0, stall_cnt}, 32'd2);
`endif

        // Randomized run with one asynchronous reset in the middle.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] t;
            if (i == 300) do_reset();
            case ($urandom_range(0, 3))
                0:       t = 32'hFFFF_FFFC;
                1:       t = $urandom;
                default: t = $urandom_range(0, 255);
            endcase
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, t,
                $urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0,
                $urandom_range(0, 2) == 0);
        end

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d exp 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 32-bit PA-RISC pipeline.
- Holds the architectural PC/nPC pair that PA-RISC delayed branching requires.
- Drives the byte address of the combinational, big-endian instruction memory and captures the returned 32-bit word into the IF/ID pipeline register.
- Handles stall, branch redirect, IF/ID nullify (flush) and halt, and feeds the decode stage.

Parameters:
- ADDR_W, 8, number of PC bits driven to the instruction memory address port.
- RESET_PC, 32'h0000_0000, PC value after reset; nPC resets to RESET_PC+4.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  hazard unit: hold PC, nPC and IF/ID.
- br_taken  input  1  ID stage: branch/jump taken this cycle.
- br_target  input  32  ID stage: branch target byte address.
- if_id_flush  input  1  nullify the IF/ID contents on the next edge.
- halt_req  input  1  stop fetching and enter HALT.
- resume  input  1  leave HALT.
- imem_addr  output  ADDR_W  byte address to instruction memory (PC[ADDR_W-1:0]).
- imem_data  input  32  instruction word from memory, same cycle (combinational).
- if_id_instr  output  32  registered instruction.
- if_id_pc  output  32  registered PC of if_id_instr.
- if_id_valid  output  1  if_id_instr is live (0 = bubble/nullified).
- halted  output  1  FSM is in HALT.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - PC=RESET_PC, nPC=RESET_PC+4.
  - if_id_instr=0, if_id_pc=0, if_id_valid=0.
  - state=BOOT, halted=0.
  - Reset asserted mid-operation discards all in-flight state immediately.
- imem_addr = PC[ADDR_W-1:0], purely combinational from the PC register. Bits above ADDR_W are ignored; the memory wraps them.
- FSM states BOOT, RUN, HALT:
  - BOOT: exactly one cycle after rst_n deasserts. No fetch; if_id_valid stays 0; PC held. Always goes to RUN.
  - RUN: per-edge priority is halt_req > stall > normal advance (see below). halt_req forces state HALT, holds PC/nPC and writes if_id_valid=0.
  - HALT: PC/nPC/IF/ID held with if_id_valid=0; halted=1. resume goes to RUN, and fetch restarts at the held PC on the next edge. halt_req together with resume in HALT stays in HALT.
- Stall rules in RUN (stall=1):
  - PC, nPC, if_id_instr, if_id_pc and if_id_valid are all held.
  - br_taken is ignored; ID must hold the request until the stall clears.
  - if_id_flush still clears if_id_valid, since flush beats stall for the valid bit.
- Normal advance in RUN (stall=0):
  - if_id_instr<=imem_data, if_id_pc<=PC, if_id_valid<=~if_id_flush.
  - br_taken=0: PC<=nPC, nPC<=nPC+4.
  - br_taken=1 (delayed branch): PC<=nPC (the delay slot), nPC<={br_target[31:2],2'b00}.
- Arithmetic:
  - nPC+4 is 32-bit modulo 2^32; 32'hFFFF_FFFC+4 = 0.
  - br_target[1:0] (privilege bits) is forced to 00.
- Latency: the word at address A appears on if_id_instr one edge after PC=A, when not stalled.

Optional Feature:
- Macro FETCH_STATS_EN.
- Defined:
  - Adds outputs fetch_cnt[15:0] and stall_cnt[15:0].
  - Both reset to 0 and saturate at 16'hFFFF.
  - fetch_cnt increments on every RUN edge that writes if_id_valid=1.
  - stall_cnt increments on every RUN edge with stall=1.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package pa_risc_pkg holds:
  - fetch_state_t enum (BOOT, RUN, HALT).
  - INSTR_W=32, PC_INC=4, NOP_INSTR=32'h0000_0000.
- One natural sub-module: pc_npc_reg. It owns PC/nPC update with inputs advance, br_taken and br_target, and outputs pc and npc.
- The IF/ID register and FSM stay in fetch_stage.

Test Plan:
- Reset then run, memory holding 4 words at 0, 4, 8, 12:
  - One BOOT cycle with if_id_valid=0.
  - Then if_id_pc = 0, 4, 8, 12 on consecutive edges, with matching if_id_instr.
- br_taken=1, br_target=32'h40 while PC=8, nPC=12:
  - Next edge fetches delay slot 12.
  - The edge after fetches 0x40.
  - br_target=32'h43 yields a fetch at 0x40.
- stall=1 for 3 cycles at PC=16:
  - if_id_*, PC and imem_addr frozen for all 3 cycles.
  - The edge after stall falls captures the word at 16.
- if_id_flush with stall both 1:
  - if_id_valid goes to 0; PC stays held.
  - With stall=0, flush gives if_id_valid=0 while PC still advances.
- Halt/resume:
  - halt_req at PC=20 gives halted=1 and if_id_valid=0, and PC stays 20 for 5 cycles.
  - resume gives the next valid if_id_pc=20.
  - rst_n pulsed low mid-run returns PC to RESET_PC asynchronously, without waiting for clk.
- Wrap, and FETCH_STATS_EN:
  - Force nPC=32'hFFFF_FFFC and check the following nPC is 0.
  - With FETCH_STATS_EN: 10 fetches plus 2 stalls give fetch_cnt=10 and stall_cnt=2.
